// File: rtl/programmable_counter_pkg.sv
// Shared encodings for the programmable counter: terminal-behaviour modes
// and count direction.
package programmable_counter_pkg;

  localparam logic [1:0] MODE_WRAP    = 2'b00;
  localparam logic [1:0] MODE_MODULO  = 2'b01;
  localparam logic [1:0] MODE_SAT     = 2'b10;
  localparam logic [1:0] MODE_ONESHOT = 2'b11;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/programmable_counter_inc_dec_unit.sv
// WIDTH-bit +/-1 step with combinational carry (up) or borrow (down) out.
module inc_dec_unit
  import programmable_counter_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic             dir,
  output logic [WIDTH-1:0] y,
  output logic             carry
);

  logic [WIDTH:0] sum;

  // Extra MSB carries out on FFFF+1 and borrows out on 0-1.
  always_comb begin
    if (dir == DIR_DOWN) begin
      sum = {1'b0, a} - {{WIDTH{1'b0}}, 1'b1};
    end else begin
      sum = {1'b0, a} + {{WIDTH{1'b0}}, 1'b1};
    end
    y     = sum[WIDTH-1:0];
    carry = sum[WIDTH];
  end

endmodule

// File: rtl/programmable_counter.sv
// Parametrised load/count register with wrap, modulo, saturate and one-shot
// terminal behaviours; state updates on the falling clock edge.
module programmable_counter
  import programmable_counter_pkg::*;
#(
  parameter int unsigned     WIDTH       = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             st,
  input  logic             en,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] limit,
  input  logic [WIDTH-1:0] X,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             wrap_pulse,
  output logic             running
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic             run_q, run_d;

  logic [WIDTH-1:0] step;
  logic             step_carry;
  logic [WIDTH-1:0] term;
  logic [WIDTH-1:0] sat_next;
  logic             at_hi;
  logic             at_zero;

  inc_dec_unit #(
    .WIDTH (WIDTH)
  ) u_inc_dec (
    .a     (cnt_q),
    .dir   (dir),
    .y     (step),
    .carry (step_carry)
  );

  always_comb begin
    if (dir == DIR_DOWN) begin
      term = '0;
    end else if (mode == MODE_WRAP) begin
      term = '1;
    end else begin
      term = limit;
    end
  end

  assign tc      = (cnt_q == term);
  assign at_hi   = (cnt_q >= limit);
  assign at_zero = (cnt_q == '0);

  // Clamped step shared by SATURATE and an active ONESHOT.
  always_comb begin
    if (dir == DIR_DOWN) begin
      sat_next = at_zero ? cnt_q : step;
    end else begin
      sat_next = at_hi ? cnt_q : step;
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    run_d  = run_q;
    if (st) begin
      cnt_d = X;
      run_d = (X != term);
    end else if (en) begin
      unique case (mode)
        MODE_WRAP: begin
          cnt_d  = step;
          wrap_d = step_carry;
        end
        MODE_MODULO: begin
          if (dir == DIR_DOWN) begin
            cnt_d  = at_zero ? limit : step;
            wrap_d = at_zero;
          end else begin
            cnt_d  = at_hi ? '0 : step;
            wrap_d = at_hi;
          end
        end
        MODE_SAT: begin
          cnt_d = sat_next;
        end
        MODE_ONESHOT: begin
          if (run_q) begin
            cnt_d = sat_next;
            run_d = (sat_next != term);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      cnt_q  <= RESET_VALUE;
      wrap_q <= 1'b0;
      run_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
      run_q  <= run_d;
    end
  end

  assign out        = cnt_q;
  assign wrap_pulse = wrap_q;
  assign running    = run_q;

endmodule

// File: tb/tb_programmable_counter.sv
// Scoreboard bench for programmable_counter (WIDTH=16, RESET_VALUE=5).
module tb_programmable_counter;

  localparam int unsigned W = 16;

  logic          clk;
  logic          rst, st, en, dir;
  logic [1:0]    mode;
  logic [W-1:0]  limit, x_in, out;
  logic          tc, wrap_pulse, running;

  programmable_counter #(
    .WIDTH       (W),
    .RESET_VALUE (16'd5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .st         (st),
    .en         (en),
    .dir        (dir),
    .mode       (mode),
    .limit      (limit),
    .X          (x_in),
    .out        (out),
    .tc         (tc),
    .wrap_pulse (wrap_pulse),
    .running    (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] out;
    logic         wp;
    logic         run;
    logic         tc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  logic [W-1:0] m_out;
  logic         m_wp, m_run;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference behaviour, written from the mode descriptions.
  task automatic model_step(input logic r, input logic s, input logic e, input logic d,
                            input logic [1:0] m, input logic [W-1:0] lim,
                            input logic [W-1:0] x, output exp_t ex);
    logic [W-1:0] t;
    logic [W-1:0] n;
    t = d ? 16'h0000 : ((m == 2'b00) ? 16'hFFFF : lim);
    if (r) begin
      m_out = 16'd5; m_wp = 1'b0; m_run = 1'b0;
    end else if (s) begin
      m_out = x; m_wp = 1'b0; m_run = (x != t);
    end else if (e) begin
      m_wp = 1'b0;
      case (m)
        2'b00: begin
          m_wp  = (m_out == t);
          m_out = d ? m_out - 16'd1 : m_out + 16'd1;
        end
        2'b01: begin
          if (!d) begin
            if (m_out >= lim) begin m_out = 16'd0; m_wp = 1'b1; end
            else m_out = m_out + 16'd1;
          end else begin
            if (m_out == 16'd0) begin m_out = lim; m_wp = 1'b1; end
            else m_out = m_out - 16'd1;
          end
        end
        default: begin
          if (m == 2'b10 || m_run) begin
            if (!d) n = (m_out >= lim) ? m_out : m_out + 16'd1;
            else    n = (m_out == 16'd0) ? m_out : m_out - 16'd1;
            if (m == 2'b11 && n == t) m_run = 1'b0;
            m_out = n;
          end
        end
      endcase
    end else begin
      m_wp = 1'b0;
    end
    ex.out = m_out;
    ex.wp  = m_wp;
    ex.run = m_run;
    ex.tc  = (m_out == t);
  endtask

  task automatic cyc(input logic r, input logic s, input logic e, input logic d,
                     input logic [1:0] m, input logic [W-1:0] lim, input logic [W-1:0] x);
    exp_t ex;
    exp_t got;
    @(posedge clk);
    #1;
    rst = r; st = s; en = e; dir = d; mode = m; limit = lim; x_in = x;
    model_step(r, s, e, d, m, lim, x, ex);
    sb.push_back(ex);
    @(negedge clk);
    #1;
    got = sb.pop_front();
    check_eq("out", {16'h0, out}, {16'h0, got.out});
    check_eq("wrap_pulse", {31'h0, wrap_pulse}, {31'h0, got.wp});
    check_eq("running", {31'h0, running}, {31'h0, got.run});
    check_eq("tc", {31'h0, tc}, {31'h0, got.tc});
  endtask

  initial begin
    rst = 1'b0; st = 1'b0; en = 1'b0; dir = 1'b0; mode = 2'b00; limit = '0; x_in = '0;
    m_out = '0; m_wp = 1'b0; m_run = 1'b0;

    cyc(1, 0, 0, 0, 2'b00, 16'd0, 16'd0);
    check_eq("reset_value", {16'h0, out}, 32'd5);

    // WRAP up across all-ones
    cyc(0, 1, 0, 0, 2'b00, 16'd0, 16'hFFFE);
    cyc(0, 0, 1, 0, 2'b00, 16'd0, 16'd0);
    check_eq("wrap_tc_at_ffff", {31'h0, tc}, 32'd1);
    cyc(0, 0, 1, 0, 2'b00, 16'd0, 16'd0);
    check_eq("wrap_pulse_at_0", {31'h0, wrap_pulse}, 32'd1);
    cyc(0, 0, 1, 0, 2'b00, 16'd0, 16'd0);
    check_eq("wrap_seq_end", {16'h0, out}, 32'h0001);

    // MODULO up limit 9
    cyc(0, 1, 0, 0, 2'b01, 16'd9, 16'd0);
    for (int i = 0; i < 12; i++) cyc(0, 0, 1, 0, 2'b01, 16'd9, 16'd0);
    check_eq("mod_up_end", {16'h0, out}, 32'd2);
    cyc(0, 1, 0, 0, 2'b01, 16'd9, 16'd12);
    cyc(0, 0, 1, 0, 2'b01, 16'd9, 16'd0);
    check_eq("mod_above_limit", {16'h0, out}, 32'd0);

    // MODULO down limit 3
    cyc(0, 1, 0, 1, 2'b01, 16'd3, 16'd1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1, 2'b01, 16'd3, 16'd0);
    check_eq("mod_down_end", {16'h0, out}, 32'd2);

    // MODULO limit 0 boundary
    cyc(0, 1, 0, 0, 2'b01, 16'd0, 16'd0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 2'b01, 16'd0, 16'd0);
    check_eq("mod_lim0_pulse", {31'h0, wrap_pulse}, 32'd1);

    // SATURATE up limit 4, then down
    cyc(0, 1, 0, 0, 2'b10, 16'd4, 16'd2);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0, 2'b10, 16'd4, 16'd0);
    check_eq("sat_hold", {16'h0, out}, 32'd4);
    cyc(0, 0, 1, 1, 2'b10, 16'd4, 16'd0);
    check_eq("sat_down", {16'h0, out}, 32'd3);

    // ONESHOT down
    cyc(0, 1, 0, 1, 2'b11, 16'd7, 16'd3);
    check_eq("oneshot_armed", {31'h0, running}, 32'd1);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 1, 2'b11, 16'd7, 16'd0);
    check_eq("oneshot_done", {31'h0, running}, 32'd0);
    cyc(0, 1, 0, 1, 2'b11, 16'd7, 16'd0);
    cyc(0, 0, 1, 1, 2'b11, 16'd7, 16'd0);

    // ONESHOT up, load at terminal value
    cyc(0, 1, 0, 0, 2'b11, 16'd6, 16'd6);
    cyc(0, 0, 1, 0, 2'b11, 16'd6, 16'd0);
    check_eq("oneshot_load_t", {16'h0, out}, 32'd6);

    // Priority
    cyc(0, 1, 1, 0, 2'b00, 16'd0, 16'h1234);
    check_eq("st_over_en", {16'h0, out}, 32'h1234);
    cyc(1, 1, 1, 0, 2'b00, 16'd0, 16'h4321);
    check_eq("rst_over_st", {16'h0, out}, 32'd5);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 2'b00, 16'd0, 16'd0);

    // Random mix
    for (int i = 0; i < 300; i++) begin
      logic [W-1:0] xr;
      xr = ($urandom_range(0, 3) == 0) ? 16'hFFFF - 16'($urandom_range(0, 3))
                                        : 16'($urandom_range(0, 20));
      cyc(($urandom_range(0, 40) == 0), ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)),
          2'($urandom_range(0, 3)), 16'($urandom_range(0, 20)), xr);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
